// File: rtl/sram_bank_ctrl.sv
// Bank-decoding controller between the core's data (A) and fetch (B) ports and an array of dual-port SRAM macros.
// Macro buses are driven combinationally in the request cycle; responses return READ_LAT+1 cycles after grant.
module sram_bank_ctrl #(
  parameter int unsigned NUM_BANKS   = 2,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned BANK_ADDR_W = 9,
  parameter int unsigned WMASK_W     = 4,
  parameter int unsigned READ_LAT    = 1,
  parameter int unsigned SEL_W       = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             a_req_i,
  output logic                             a_gnt_o,
  input  logic                             a_we_i,
  input  logic [WMASK_W-1:0]               a_be_i,
  input  logic [SEL_W+BANK_ADDR_W-1:0]     a_addr_i,
  input  logic [DATA_W-1:0]                a_wdata_i,
  output logic                             a_rvalid_o,
  output logic [DATA_W-1:0]                a_rdata_o,
  output logic                             a_err_o,
  input  logic                             b_req_i,
  output logic                             b_gnt_o,
  input  logic [SEL_W+BANK_ADDR_W-1:0]     b_addr_i,
  output logic                             b_rvalid_o,
  output logic [DATA_W-1:0]                b_rdata_o,
  output logic                             b_err_o,
  output logic [NUM_BANKS-1:0]             sram_clk0_o,
  output logic [NUM_BANKS-1:0]             sram_clk1_o,
  output logic [NUM_BANKS-1:0]             sram_csb0_o,
  output logic [NUM_BANKS-1:0]             sram_csb1_o,
  output logic [NUM_BANKS-1:0]             sram_web0_o,
  output logic [NUM_BANKS*WMASK_W-1:0]     sram_wmask0_o,
  output logic [NUM_BANKS*BANK_ADDR_W-1:0] sram_addr0_o,
  output logic [NUM_BANKS*BANK_ADDR_W-1:0] sram_addr1_o,
  output logic [NUM_BANKS*DATA_W-1:0]      sram_din0_o,
  input  logic [NUM_BANKS*DATA_W-1:0]      sram_dout0_i,
  input  logic [NUM_BANKS*DATA_W-1:0]      sram_dout1_i
);

  localparam int unsigned AW = SEL_W + BANK_ADDR_W;
  localparam logic [SEL_W:0] NB = NUM_BANKS[SEL_W:0];

  typedef struct packed {
    logic             valid;
    logic             rd;
    logic             err;
    logic [SEL_W-1:0] bank;
  } rsp_t;

  logic                   a_go, b_go, collide;
  logic [SEL_W-1:0]       a_bank, b_bank;
  logic [BANK_ADDR_W-1:0] a_off, b_off;
  logic                   a_ok, b_ok;
  rsp_t                   a_pipe [READ_LAT];
  rsp_t                   b_pipe [READ_LAT];
  rsp_t                   a_new, b_new, a_tail, b_tail;
  logic [DATA_W-1:0]      a_dout, b_dout;

  assign sram_clk0_o = {NUM_BANKS{clk_i}};
  assign sram_clk1_o = {NUM_BANKS{clk_i}};

  assign a_bank = a_addr_i[AW-1:BANK_ADDR_W];
  assign b_bank = b_addr_i[AW-1:BANK_ADDR_W];
  assign a_off  = a_addr_i[BANK_ADDR_W-1:0];
  assign b_off  = b_addr_i[BANK_ADDR_W-1:0];
  assign a_ok   = ({1'b0, a_bank} < NB);
  assign b_ok   = ({1'b0, b_bank} < NB);

  // Grants are gated by rst_ni so every output sits at its reset value while reset is held.
  assign a_go    = rst_ni & a_req_i;
  assign collide = a_go & a_we_i & b_req_i & (a_addr_i == b_addr_i);
  assign b_go    = rst_ni & b_req_i & ~collide;
  assign a_gnt_o = a_go;
  assign b_gnt_o = b_go;

  always_comb begin
    sram_csb0_o   = '1;
    sram_web0_o   = '1;
    sram_csb1_o   = '1;
    sram_wmask0_o = '0;
    sram_addr0_o  = '0;
    sram_addr1_o  = '0;
    sram_din0_o   = '0;
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      if (a_go && a_ok && (a_bank == SEL_W'(b))) begin
        sram_csb0_o[b] = 1'b0;
        sram_web0_o[b] = ~a_we_i;
        sram_addr0_o[b*BANK_ADDR_W +: BANK_ADDR_W] = a_off;
        if (a_we_i) begin
          sram_wmask0_o[b*WMASK_W +: WMASK_W] = a_be_i;
          sram_din0_o[b*DATA_W +: DATA_W]     = a_wdata_i;
        end
      end
      if (b_go && b_ok && (b_bank == SEL_W'(b))) begin
        sram_csb1_o[b] = 1'b0;
        sram_addr1_o[b*BANK_ADDR_W +: BANK_ADDR_W] = b_off;
      end
    end
  end

  assign a_new  = '{valid: a_go, rd: ~a_we_i, err: ~a_ok, bank: a_bank};
  assign b_new  = '{valid: b_go, rd: 1'b1,    err: ~b_ok, bank: b_bank};
  assign a_tail = a_pipe[READ_LAT-1];
  assign b_tail = b_pipe[READ_LAT-1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < READ_LAT; i++) begin
        a_pipe[i] <= '0;
        b_pipe[i] <= '0;
      end
    end else begin
      a_pipe[0] <= a_new;
      b_pipe[0] <= b_new;
      for (int unsigned i = 1; i < READ_LAT; i++) begin
        a_pipe[i] <= a_pipe[i-1];
        b_pipe[i] <= b_pipe[i-1];
      end
    end
  end

  // The tail stage lines up with the cycle the recorded bank presents dout.
  always_comb begin
    a_dout = '0;
    b_dout = '0;
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      if (a_tail.bank == SEL_W'(b)) a_dout = sram_dout0_i[b*DATA_W +: DATA_W];
      if (b_tail.bank == SEL_W'(b)) b_dout = sram_dout1_i[b*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_rvalid_o <= 1'b0;
      a_err_o    <= 1'b0;
      a_rdata_o  <= '0;
      b_rvalid_o <= 1'b0;
      b_err_o    <= 1'b0;
      b_rdata_o  <= '0;
    end else begin
      a_rvalid_o <= a_tail.valid;
      a_err_o    <= a_tail.valid & a_tail.err;
      if (a_tail.valid) a_rdata_o <= (a_tail.rd && !a_tail.err) ? a_dout : '0;
      b_rvalid_o <= b_tail.valid;
      b_err_o    <= b_tail.valid & b_tail.err;
      if (b_tail.valid) b_rdata_o <= b_tail.err ? '0 : b_dout;
    end
  end

endmodule

// File: tb/tb_sram_bank_ctrl.sv
// Bench for sram_bank_ctrl with three banks (one out-of-range index) and two-cycle macro latency.
// Vector table checks request-cycle macro drive; a queue scoreboard checks responses.
module tb_sram_bank_ctrl;

  localparam int NB  = 3;
  localparam int LAT = 2;
  localparam int DW  = 32;
  localparam int BAW = 9;
  localparam int SW  = 2;
  localparam int AW  = SW + BAW;

  logic              clk_i, rst_ni;
  logic              a_req_i, a_gnt_o, a_we_i, a_rvalid_o, a_err_o;
  logic [3:0]        a_be_i;
  logic [AW-1:0]     a_addr_i, b_addr_i;
  logic [DW-1:0]     a_wdata_i, a_rdata_o, b_rdata_o;
  logic              b_req_i, b_gnt_o, b_rvalid_o, b_err_o;
  logic [NB-1:0]     sram_clk0_o, sram_clk1_o, sram_csb0_o, sram_csb1_o, sram_web0_o;
  logic [NB*4-1:0]   sram_wmask0_o;
  logic [NB*BAW-1:0] sram_addr0_o, sram_addr1_o;
  logic [NB*DW-1:0]  sram_din0_o, sram_dout0_i, sram_dout1_i;

  sram_bank_ctrl #(.NUM_BANKS(NB), .READ_LAT(LAT)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .a_req_i(a_req_i), .a_gnt_o(a_gnt_o), .a_we_i(a_we_i), .a_be_i(a_be_i),
    .a_addr_i(a_addr_i), .a_wdata_i(a_wdata_i), .a_rvalid_o(a_rvalid_o),
    .a_rdata_o(a_rdata_o), .a_err_o(a_err_o),
    .b_req_i(b_req_i), .b_gnt_o(b_gnt_o), .b_addr_i(b_addr_i),
    .b_rvalid_o(b_rvalid_o), .b_rdata_o(b_rdata_o), .b_err_o(b_err_o),
    .sram_clk0_o(sram_clk0_o), .sram_clk1_o(sram_clk1_o),
    .sram_csb0_o(sram_csb0_o), .sram_csb1_o(sram_csb1_o), .sram_web0_o(sram_web0_o),
    .sram_wmask0_o(sram_wmask0_o), .sram_addr0_o(sram_addr0_o), .sram_addr1_o(sram_addr1_o),
    .sram_din0_o(sram_din0_o), .sram_dout0_i(sram_dout0_i), .sram_dout1_i(sram_dout1_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] init_word(input int b, input int a);
    return 32'hA500_0000 | (32'(b) << 16) | 32'(a);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] din,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int k = 0; k < 4; k++) if (m[k]) r[8*k +: 8] = din[8*k +: 8];
    return r;
  endfunction

  // Behavioural macro array: write-through storage, LAT-cycle read pipe, garbage when idle.
  logic [31:0] mem [NB][512];
  bit          wr  [NB][512];
  logic [31:0] rd0 [NB][LAT];
  logic [31:0] rd1 [NB][LAT];

  function automatic logic [31:0] mem_word(input int b, input int a);
    return wr[b][a] ? mem[b][a] : init_word(b, a);
  endfunction

  always @(posedge clk_i) begin
    for (int b = 0; b < NB; b++) begin
      if (!sram_csb0_o[b]) begin
        if (!sram_web0_o[b]) begin
          mem[b][sram_addr0_o[b*BAW +: BAW]] <= merge(mem_word(b, int'(sram_addr0_o[b*BAW +: BAW])),
                                                      sram_din0_o[b*DW +: DW], sram_wmask0_o[b*4 +: 4]);
          wr[b][sram_addr0_o[b*BAW +: BAW]] <= 1'b1;
          rd0[b][0] <= $urandom;
        end else begin
          rd0[b][0] <= mem_word(b, int'(sram_addr0_o[b*BAW +: BAW]));
        end
      end else begin
        rd0[b][0] <= $urandom;
      end
      if (!sram_csb1_o[b]) rd1[b][0] <= mem_word(b, int'(sram_addr1_o[b*BAW +: BAW]));
      else                 rd1[b][0] <= $urandom;
      for (int k = 1; k < LAT; k++) begin
        rd0[b][k] <= rd0[b][k-1];
        rd1[b][k] <= rd1[b][k-1];
      end
    end
  end

  always_comb begin
    sram_dout0_i = '0;
    sram_dout1_i = '0;
    for (int b = 0; b < NB; b++) begin
      sram_dout0_i[b*DW +: DW] = rd0[b][LAT-1];
      sram_dout1_i[b*DW +: DW] = rd1[b][LAT-1];
    end
  end

  // Reference contents, updated when a write is granted.
  logic [31:0] ref_mem [NB][512];
  bit          ref_wr  [NB][512];

  function automatic logic [31:0] ref_read(input int b, input int a);
    return ref_wr[b][a] ? ref_mem[b][a] : init_word(b, a);
  endfunction

  typedef struct {
    int          due;
    logic        err;
    logic [31:0] data;
  } rsp_e_t;
  rsp_e_t a_q[$];
  rsp_e_t b_q[$];

  logic [31:0] a_last, b_last;
  always @(negedge clk_i) begin : mon
    rsp_e_t e;
    if (!rst_ni) begin
      a_last = '0;
      b_last = '0;
    end else begin
      if (a_rvalid_o) begin
        if (a_q.size() == 0) chk("a_spurious_rvalid", 1, 0);
        else begin
          e = a_q.pop_front();
          chk("a_rsp_cycle", cyc, e.due);
          chk("a_rsp_err", a_err_o, e.err);
          chk("a_rsp_data", a_rdata_o, e.data);
          a_last = e.data;
        end
      end else begin
        chk("a_rdata_hold", a_rdata_o, a_last);
        if (a_q.size() != 0 && a_q[0].due <= cyc) begin
          chk("a_rsp_missing", 0, 1);
          void'(a_q.pop_front());
        end
      end
      if (b_rvalid_o) begin
        if (b_q.size() == 0) chk("b_spurious_rvalid", 1, 0);
        else begin
          e = b_q.pop_front();
          chk("b_rsp_cycle", cyc, e.due);
          chk("b_rsp_err", b_err_o, e.err);
          chk("b_rsp_data", b_rdata_o, e.data);
          b_last = e.data;
        end
      end else begin
        chk("b_rdata_hold", b_rdata_o, b_last);
        if (b_q.size() != 0 && b_q[0].due <= cyc) begin
          chk("b_rsp_missing", 0, 1);
          void'(b_q.pop_front());
        end
      end
    end
  end

  typedef struct {
    logic          a_req, a_we;
    logic [3:0]    a_be;
    logic [AW-1:0] a_addr;
    logic [31:0]   a_wdata;
    logic          b_req;
    logic [AW-1:0] b_addr;
    logic          a_gnt, b_gnt;
    logic [2:0]    csb0, web0, csb1;
  } vec_t;

  task automatic apply(input vec_t v, input int idx);
    logic [127:0] ea0, ea1, ed, ew;
    int ab, ao, bb, bo;
    rsp_e_t e;
    a_req_i = v.a_req; a_we_i = v.a_we; a_be_i = v.a_be;
    a_addr_i = v.a_addr; a_wdata_i = v.a_wdata;
    b_req_i = v.b_req; b_addr_i = v.b_addr;
    #2;
    chk($sformatf("v%0d_a_gnt", idx), a_gnt_o, v.a_gnt);
    chk($sformatf("v%0d_b_gnt", idx), b_gnt_o, v.b_gnt);
    chk($sformatf("v%0d_csb0", idx), sram_csb0_o, v.csb0);
    chk($sformatf("v%0d_web0", idx), sram_web0_o, v.web0);
    chk($sformatf("v%0d_csb1", idx), sram_csb1_o, v.csb1);
    ab = int'(v.a_addr[AW-1:BAW]); ao = int'(v.a_addr[BAW-1:0]);
    bb = int'(v.b_addr[AW-1:BAW]); bo = int'(v.b_addr[BAW-1:0]);
    ea0 = '0; ea1 = '0; ed = '0; ew = '0;
    if (v.a_gnt && ab < NB) begin
      ea0[ab*BAW +: BAW] = v.a_addr[BAW-1:0];
      if (v.a_we) begin
        ed[ab*DW +: DW] = v.a_wdata;
        ew[ab*4 +: 4]   = v.a_be;
      end
    end
    if (v.b_gnt && bb < NB) ea1[bb*BAW +: BAW] = v.b_addr[BAW-1:0];
    chk($sformatf("v%0d_addr0", idx), sram_addr0_o, ea0);
    chk($sformatf("v%0d_addr1", idx), sram_addr1_o, ea1);
    chk($sformatf("v%0d_din0", idx), sram_din0_o, ed);
    chk($sformatf("v%0d_wmask0", idx), sram_wmask0_o, ew);
    if (v.a_gnt) begin
      e.due  = cyc + LAT + 1;
      e.err  = (ab >= NB);
      e.data = (ab >= NB || v.a_we) ? 32'h0 : ref_read(ab, ao);
      a_q.push_back(e);
    end
    if (v.b_gnt) begin
      e.due  = cyc + LAT + 1;
      e.err  = (bb >= NB);
      e.data = (bb >= NB) ? 32'h0 : ref_read(bb, bo);
      b_q.push_back(e);
    end
    if (v.a_gnt && v.a_we && ab < NB) begin
      ref_mem[ab][ao] = merge(ref_read(ab, ao), v.a_wdata, v.a_be);
      ref_wr[ab][ao]  = 1'b1;
    end
    @(posedge clk_i); #1;
  endtask

  task automatic idle();
    a_req_i = 1'b0; a_we_i = 1'b0; b_req_i = 1'b0;
    a_addr_i = '0; b_addr_i = '0; a_wdata_i = '0; a_be_i = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_a_gnt"}, a_gnt_o, 0);
    chk({tag, "_b_gnt"}, b_gnt_o, 0);
    chk({tag, "_csb0"}, sram_csb0_o, 3'b111);
    chk({tag, "_csb1"}, sram_csb1_o, 3'b111);
    chk({tag, "_web0"}, sram_web0_o, 3'b111);
    chk({tag, "_addr0"}, sram_addr0_o, 0);
    chk({tag, "_din0"}, sram_din0_o, 0);
    chk({tag, "_wmask0"}, sram_wmask0_o, 0);
    chk({tag, "_a_rvalid"}, a_rvalid_o, 0);
    chk({tag, "_a_rdata"}, a_rdata_o, 0);
    chk({tag, "_a_err"}, a_err_o, 0);
    chk({tag, "_b_rvalid"}, b_rvalid_o, 0);
    chk({tag, "_b_rdata"}, b_rdata_o, 0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  vec_t vecs[$];
  int   rv_cnt;

  initial begin
    idle();
    rst_ni = 1'b0;
    #3;
    check_reset_outputs("rst0");
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    @(posedge clk_i); #1;

    //           a_req a_we be    a_addr   a_wdata        b_req b_addr   ag bg csb0    web0    csb1
    vecs.push_back('{1'b1, 1'b1, 4'hF, 11'h203, 32'hDEADBEEF, 1'b0, 11'h000, 1, 0, 3'b101, 3'b101, 3'b111});
    vecs.push_back('{1'b1, 1'b0, 4'h0, 11'h203, 32'h0,        1'b1, 11'h001, 1, 1, 3'b101, 3'b111, 3'b110});
    vecs.push_back('{1'b1, 1'b1, 4'h3, 11'h010, 32'h12345678, 1'b1, 11'h010, 1, 0, 3'b110, 3'b110, 3'b111});
    vecs.push_back('{1'b0, 1'b1, 4'hF, 11'h010, 32'h0,        1'b1, 11'h010, 0, 1, 3'b111, 3'b111, 3'b110});
    vecs.push_back('{1'b1, 1'b0, 4'h0, 11'h600, 32'h0,        1'b1, 11'h400, 1, 1, 3'b111, 3'b111, 3'b011});
    vecs.push_back('{1'b1, 1'b1, 4'hC, 11'h205, 32'hCAFEF00D, 1'b1, 11'h203, 1, 1, 3'b101, 3'b101, 3'b101});
    vecs.push_back('{1'b1, 1'b0, 4'h0, 11'h203, 32'h0,        1'b1, 11'h203, 1, 1, 3'b101, 3'b111, 3'b101});
    vecs.push_back('{1'b0, 1'b0, 4'h0, 11'h000, 32'h0,        1'b1, 11'h600, 0, 1, 3'b111, 3'b111, 3'b111});
    vecs.push_back('{1'b1, 1'b1, 4'hF, 11'h400, 32'h0BADC0DE, 1'b1, 11'h000, 1, 1, 3'b011, 3'b011, 3'b110});
    vecs.push_back('{1'b0, 1'b0, 4'h0, 11'h000, 32'h0,        1'b1, 11'h000, 0, 1, 3'b111, 3'b111, 3'b110});
    vecs.push_back('{1'b0, 1'b0, 4'h0, 11'h000, 32'h0,        1'b1, 11'h200, 0, 1, 3'b111, 3'b111, 3'b101});
    vecs.push_back('{1'b0, 1'b0, 4'h0, 11'h000, 32'h0,        1'b1, 11'h001, 0, 1, 3'b111, 3'b111, 3'b110});
    vecs.push_back('{1'b1, 1'b1, 4'hF, 11'h600, 32'h11111111, 1'b0, 11'h000, 1, 0, 3'b111, 3'b111, 3'b111});
    vecs.push_back('{1'b0, 1'b1, 4'hF, 11'h123, 32'h22222222, 1'b0, 11'h123, 0, 0, 3'b111, 3'b111, 3'b111});
    vecs.push_back('{1'b1, 1'b0, 4'h0, 11'h205, 32'h0,        1'b1, 11'h400, 1, 1, 3'b101, 3'b111, 3'b011});
    vecs.push_back('{1'b1, 1'b0, 4'h0, 11'h010, 32'h0,        1'b1, 11'h203, 1, 1, 3'b110, 3'b111, 3'b101});

    foreach (vecs[i]) apply(vecs[i], i);

    idle();
    for (int i = 0; i < 20 && (a_q.size() != 0 || b_q.size() != 0); i++) begin
      @(posedge clk_i); #1;
    end
    chk("drain_a", a_q.size(), 0);
    chk("drain_b", b_q.size(), 0);
    chk("rdata_nonzero_before_reset", (a_rdata_o != 0), 1);

    // Reset one cycle after an A read grant: outputs clear at once, nothing returns later.
    a_req_i = 1'b1; a_we_i = 1'b0; a_addr_i = 11'h203;
    b_req_i = 1'b1; b_addr_i = 11'h001;
    @(posedge clk_i); #1;
    rst_ni = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    a_q.delete();
    b_q.delete();
    idle();
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    rv_cnt = 0;
    repeat (6) begin
      @(negedge clk_i);
      if (a_rvalid_o || b_rvalid_o) rv_cnt++;
    end
    chk("no_rvalid_after_reset", rv_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
